// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-port synchronous memory (1-cycle read latency).
// Define MEM_ARB_STARVE_GUARD_EN to build the fetch starvation guard; otherwise data priority is absolute.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_mask,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_ren,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } resp_e;

  resp_e resp_q, resp_d;
  logic  fetch_win;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       starved;

  assign starved   = (starve_q == LIMIT);
  assign fetch_win = i_req && (!d_req || starved);

  always_comb begin
    starve_d = '0;
    if (i_req && !i_gnt) begin
      starve_d = starved ? starve_q : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fetch_win = i_req && !d_req;
`endif

  // Grants are gated by rst_n so nothing is issued while reset is held.
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = d_addr;
    mem_wdata = d_wdata;
    mem_mask  = '0;
    resp_d    = IDLE;
    if (rst_n) begin
      if (fetch_win) begin
        i_gnt    = 1'b1;
        mem_ren  = 1'b1;
        mem_addr = i_addr;
        resp_d   = RESP_I;
      end else if (d_req) begin
        d_gnt = 1'b1;
        if (d_we) begin
          mem_wen  = 1'b1;
          mem_mask = d_mask;
        end else begin
          mem_ren = 1'b1;
          resp_d  = RESP_D;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= IDLE;
    end else begin
      resp_q <= resp_d;
    end
  end

  assign i_rvalid = (resp_q == RESP_I);
  assign d_rvalid = (resp_q == RESP_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a behavioural arbitration/memory model.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [3:0]    d_mask;
  logic [AW-1:0] mem_addr;
  logic          mem_ren, mem_wen;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_mask;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  // Memory attached to the DUT: 256 words, preloaded through the pre_* port.
  logic [31:0] mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_ren) mem_rdata <= mem[mem_addr[9:2]];
  end

  // Reference model state
  logic [31:0] gold [0:255];
  int unsigned lost;
  bit          rv_i, rv_d;
  logic [31:0] rv_data;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] init_word(int unsigned i);
    if (i == 16) return 32'h11111111;
    if (i == 64) return 32'h00000013;
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    lost = 0;
    rv_i = 1'b0;
    rv_d = 1'b0;
  endtask

  // Called just after a negedge with inputs set; checks the cycle and advances to the next negedge.
  task automatic step(output bit ig, output bit dg);
    bit ewin_i, ewin_d, ewr;
    #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
    ewin_i = i_req && (!d_req || lost >= SL);
`else
    ewin_i = i_req && !d_req;
`endif
    ewin_d = d_req && !ewin_i;
    ewr    = ewin_d && d_we;
    check_eq("i_gnt", i_gnt, ewin_i);
    check_eq("d_gnt", d_gnt, ewin_d);
    check_eq("i_rvalid", i_rvalid, rv_i);
    check_eq("d_rvalid", d_rvalid, rv_d);
    if (rv_i) check_eq("i_rdata", i_rdata, rv_data);
    if (rv_d) check_eq("d_rdata", d_rdata, rv_data);
    check_eq("mem_ren", mem_ren, ewin_i || (ewin_d && !d_we));
    check_eq("mem_wen", mem_wen, ewr);
    check_eq("mem_mask", mem_mask, ewr ? d_mask : 4'h0);
    if (ewin_i) check_eq("mem_addr_i", mem_addr, i_addr);
    if (ewin_d) check_eq("mem_addr_d", mem_addr, d_addr);
    if (ewr) check_eq("mem_wdata", mem_wdata, d_wdata);
    rv_i = ewin_i;
    rv_d = ewin_d && !d_we;
    if (ewin_i) rv_data = gold[i_addr[9:2]];
    else if (rv_d) rv_data = gold[d_addr[9:2]];
    if (ewr)
      for (int b = 0; b < 4; b++)
        if (d_mask[b]) gold[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
    lost = (i_req && !ewin_i) ? ((lost < SL) ? lost + 1 : SL) : 0;
    ig = ewin_i;
    dg = ewin_d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit ig, dg;
    int first_i;
    rst_n   = 1'b0;
    i_req   = 1'b1;
    d_req   = 1'b1;
    d_we    = 1'b0;
    i_addr  = 32'h100;
    d_addr  = 32'h200;
    d_wdata = '0;
    d_mask  = '0;
    pre_en  = 1'b1;
    model_reset();

    // Preload while reset is held with both requests asserted.
    for (int unsigned i = 0; i < 256; i++) begin
      pre_idx = 8'(i);
      pre_val = init_word(i);
      gold[i] = pre_val;
      if (i < 3) begin
        #1;
        check_eq("rst_i_gnt", i_gnt, 1'b0);
        check_eq("rst_d_gnt", d_gnt, 1'b0);
        check_eq("rst_i_rvalid", i_rvalid, 1'b0);
        check_eq("rst_d_rvalid", d_rvalid, 1'b0);
        check_eq("rst_mem_ren", mem_ren, 1'b0);
        check_eq("rst_mem_wen", mem_wen, 1'b0);
        check_eq("rst_mem_mask", mem_mask, 4'h0);
      end
      @(negedge clk);
    end
    pre_en = 1'b0;
    rst_n  = 1'b1;

    // Both held: first cycle after reset is a data grant, then starvation behaviour.
    first_i = -1;
    for (int c = 0; c < 8; c++) begin
      step(ig, dg);
      if (c == 0) check_eq("rst_first_dgnt", dg, 1'b1);
      if (ig && first_i < 0) first_i = c;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    check_eq("starve_first_ignt", 64'(first_i), 64'(SL));
`else
    check_eq("starve_first_ignt", 64'(first_i), 64'(-1));
`endif
    i_req = 1'b0;
    d_req = 1'b0;
    step(ig, dg);

    // Fetch only
    i_req  = 1'b1;
    i_addr = 32'h100;
    step(ig, dg);
    check_eq("fetch_gnt", ig, 1'b1);
    i_req = 1'b0;
    #1 check_eq("fetch_data", i_rdata, 32'h00000013);
    step(ig, dg);

    // Byte write then fetch read-back
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h40;
    d_wdata = 32'hAABBCCDD;
    d_mask  = 4'b0101;
    step(ig, dg);
    d_req  = 1'b0;
    d_we   = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h40;
    step(ig, dg);
    i_req = 1'b0;
    #1 check_eq("bytewr_readback", i_rdata, 32'h11BB11DD);
    step(ig, dg);

    // Reset in the cycle after a fetch grant
    i_req  = 1'b1;
    i_addr = 32'h100;
    step(ig, dg);
    i_req = 1'b0;
    rst_n = 1'b0;
    #1 check_eq("rst_mid_rvalid", i_rvalid, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(ig, dg);
    step(ig, dg);

    // Random traffic; requests held until granted
    for (int n = 0; n < 600; n++) begin
      if (!i_req && $urandom_range(0, 2) != 0) begin
        i_req  = 1'b1;
        i_addr = {22'b0, 8'($urandom), 2'b00};
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom);
        d_addr  = {22'b0, 8'($urandom), 2'b00};
        d_wdata = $urandom;
        d_mask  = 4'($urandom);
      end
      step(ig, dg);
      if (ig) i_req = 1'b0;
      if (dg) d_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
